// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and digit-adjust helper
// for the shared binary-to-BCD conversion block.
package bcd_pkg;

    localparam int BIN_W     = 8;
    localparam int DIGIT_W   = 4;
    localparam int NDIGITS   = 3;
    localparam int ITER_LAST = BIN_W - 1;
    localparam int DIG_W     = DIGIT_W * NDIGITS;
    localparam int CNT_W     = $clog2(BIN_W);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    // Double-dabble correction: a digit of 5 or more would carry
    // past 9 after the next doubling, so pre-bias it by 3.
    function automatic logic [DIGIT_W-1:0] add3(
        input logic [DIGIT_W-1:0] d
    );
        return (d >= DIGIT_W'(5)) ? d + DIGIT_W'(3) : d;
    endfunction

endpackage

// File: rtl/bcd_dd_seq.sv
// Iterative shift-add-3 converter: one adjust+shift per clock,
// eight iterations per 8-bit value.
module bcd_dd_seq
    import bcd_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [BIN_W-1:0]   data_in,
    output logic               done,
    output logic [DIGIT_W-1:0] hundreds,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] ones
);

    logic [BIN_W-1:0] shreg;
    logic [BIN_W-1:0] shreg_next;
    logic [DIG_W-1:0] digits;
    logic [DIG_W-1:0] adj;
    logic [DIG_W-1:0] digits_next;
    logic [CNT_W-1:0] count;
    logic             run;

    always_comb begin
        adj = '0;
        for (int g = 0; g < NDIGITS; g++) begin
            adj[g*DIGIT_W +: DIGIT_W] = add3(digits[g*DIGIT_W +: DIGIT_W]);
        end
        digits_next = {adj[DIG_W-2:0], shreg[BIN_W-1]};
        shreg_next  = {shreg[BIN_W-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg  <= '0;
            digits <= '0;
            count  <= '0;
            run    <= 1'b0;
        end else if (start) begin
            shreg  <= data_in;
            digits <= '0;
            count  <= '0;
            run    <= 1'b1;
        end else if (run) begin
            shreg  <= shreg_next;
            digits <= digits_next;
            count  <= count + CNT_W'(1);
            if (count == CNT_W'(ITER_LAST)) begin
                run <= 1'b0;
            end
        end
    end

    // Digits are the result of the iteration in progress, so they
    // hold the final value while done marks the last iteration.
    assign done     = run && (count == CNT_W'(ITER_LAST));
    assign hundreds = digits_next[3*DIGIT_W-1 -: DIGIT_W];
    assign tens     = digits_next[2*DIGIT_W-1 -: DIGIT_W];
    assign ones     = digits_next[DIGIT_W-1 -: DIGIT_W];

endmodule

// File: rtl/bcd_convert_arbiter.sv
// Round-robin front end sharing one sequential BCD converter
// among NREQ requesters; results are tagged with requester id.
module bcd_convert_arbiter
    import bcd_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*BIN_W-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  res_valid,
    output logic [IDW-1:0]        res_id,
    output logic [DIGIT_W-1:0]    res_hundreds,
    output logic [DIGIT_W-1:0]    res_tens,
    output logic [DIGIT_W-1:0]    res_ones,
    output logic                  busy
);

    state_t             state;
    state_t             state_next;
    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     ptr_next;
    logic [IDW-1:0]     id;
    logic [IDW-1:0]     win;
    logic               found;
    int                 idx;
    logic               hs;
    logic [BIN_W-1:0]   win_data;
    logic               conv_done;
    logic [DIGIT_W-1:0] conv_h;
    logic [DIGIT_W-1:0] conv_t;
    logic [DIGIT_W-1:0] conv_o;

    // First valid requester at or after the pointer, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    assign req_ready = (rst_n && state == IDLE && found)
                     ? (NREQ'(1) << win) : '0;
    assign hs        = |(req_valid & req_ready);
    assign win_data  = req_data[int'(win)*BIN_W +: BIN_W];
    assign ptr_next  = (int'(win) == NREQ - 1) ? '0 : win + IDW'(1);
    assign busy      = (state != IDLE);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (hs) state_next = CONV;
            CONV: if (conv_done) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= '0;
            id           <= '0;
            res_valid    <= 1'b0;
            res_id       <= '0;
            res_hundreds <= '0;
            res_tens     <= '0;
            res_ones     <= '0;
        end else begin
            res_valid <= 1'b0;
            if (hs) begin
                id  <= win;
                ptr <= ptr_next;
            end
            if (state == CONV && conv_done) begin
                res_valid    <= 1'b1;
                res_id       <= id;
                res_hundreds <= conv_h;
                res_tens     <= conv_t;
                res_ones     <= conv_o;
            end
        end
    end

    bcd_dd_seq u_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (hs),
        .data_in  (win_data),
        .done     (conv_done),
        .hundreds (conv_h),
        .tens     (conv_t),
        .ones     (conv_o)
    );

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Scenario bench for bcd_convert_arbiter with a decimal-arithmetic
// reference model and round-robin fairness tracking.
module tb_bcd_convert_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic [1:0]  res_id;
    logic [3:0]  res_hundreds;
    logic [3:0]  res_tens;
    logic [3:0]  res_ones;
    logic        busy;

    int total = 0;
    int passed = 0;
    int cyc = 0;

    typedef struct {
        int id;
        int val;
    } exp_t;

    always #5 clk = ~clk;

    bcd_convert_arbiter #(.NREQ(4), .IDW(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .res_valid    (res_valid),
        .res_id       (res_id),
        .res_hundreds (res_hundreds),
        .res_tens     (res_tens),
        .res_ones     (res_ones),
        .busy         (busy)
    );

    function automatic logic [11:0] dec(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_res(output int n);
        n = 0;
        while (res_valid !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (req_ready === 4'b0000 && n < 30) begin
            tick();
            n++;
        end
    endtask

    task automatic apply_reset();
        req_valid = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        req_valid = 4'hf;
        req_data = $urandom;
        rst_n = 1'b0;
        repeat (3) tick();
        total++;
        if (req_ready !== 4'b0) begin
            $display("FAIL reset_ready got=%b want=0000", req_ready);
        end else passed++;
        total++;
        if ({busy, res_valid, res_id, res_hundreds, res_tens, res_ones}
            !== 16'h0) begin
            $display("FAIL reset_outputs got=%h want=0000",
                {busy, res_valid, res_id, res_hundreds, res_tens, res_ones});
        end else passed++;
        req_valid = '0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_zero();
        int n;
        req_valid = 4'b0001;
        req_data = '0;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            $display("FAIL single_ready got=%b want=0001", req_ready);
        end else passed++;
        tick();
        req_valid = '0;
        total++;
        if (busy !== 1'b1) begin
            $display("FAIL single_busy got=%b want=1", busy);
        end else passed++;
        wait_res(n);
        total++;
        if (n != 8) begin
            $display("FAIL single_latency got=%0d want=8", n);
        end else passed++;
        total++;
        if ({res_id, res_hundreds, res_tens, res_ones} !== 14'h0) begin
            $display("FAIL single_digits got=%h want=0000",
                {res_id, res_hundreds, res_tens, res_ones});
        end else passed++;
        tick();
        total++;
        if (res_valid !== 1'b0) begin
            $display("FAIL single_pulse got=%b want=0", res_valid);
        end else passed++;
    endtask

    task automatic test_back_to_back();
        int vals[3] = '{99, 100, 255};
        int n;
        int last_hs = 0;
        req_valid = 4'b0010;
        req_data = {16'h0, 8'(vals[0]), 8'h0};
        #1;
        for (int k = 0; k < 3; k++) begin
            wait_ready(n);
            total++;
            if (req_ready !== 4'b0010) begin
                $display("FAIL b2b_ready k=%0d got=%b want=0010", k, req_ready);
            end else passed++;
            if (k > 0) begin
                total++;
                if (cyc - last_hs != 10) begin
                    $display("FAIL b2b_gap got=%0d want=10", cyc - last_hs);
                end else passed++;
            end
            last_hs = cyc;
            tick();
            req_data[15:8] = (k < 2) ? 8'(vals[k+1]) : 8'($urandom);
            wait_res(n);
            total++;
            if ({res_valid, res_id, res_hundreds, res_tens, res_ones} !==
                {1'b1, 2'd1, dec(vals[k])}) begin
                $display("FAIL b2b_result k=%0d got=%h want=%h", k,
                    {res_valid, res_id, res_hundreds, res_tens, res_ones},
                    {1'b1, 2'd1, dec(vals[k])});
            end else passed++;
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_all_four();
        int vals[4] = '{12, 34, 56, 78};
        int n;
        int e;
        apply_reset();
        req_data = {8'd78, 8'd56, 8'd34, 8'd12};
        req_valid = 4'b1111;
        #1;
        for (int g = 0; g < 5; g++) begin
            e = g % 4;
            wait_ready(n);
            total++;
            if (req_ready !== 4'(1 << e)) begin
                $display("FAIL four_grant g=%0d got=%b want=%b",
                    g, req_ready, 4'(1 << e));
            end else passed++;
            tick();
            wait_res(n);
            total++;
            if ({res_valid, res_id, res_hundreds, res_tens, res_ones} !==
                {1'b1, 2'(e), dec(vals[e])}) begin
                $display("FAIL four_result g=%0d got=%h want=%h", g,
                    {res_valid, res_id, res_hundreds, res_tens, res_ones},
                    {1'b1, 2'(e), dec(vals[e])});
            end else passed++;
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_wrap();
        int n;
        bit seen3 = 0;
        req_valid = 4'b1000;
        req_data = {8'd77, 8'd42, 16'h0};
        #1;
        wait_ready(n);
        total++;
        if (req_ready !== 4'b1000) begin
            $display("FAIL wrap_first got=%b want=1000", req_ready);
        end else passed++;
        tick();
        req_valid = 4'b1100;
        for (n = 0; n < 20; n++) begin
            total++;
            if ($countones(req_ready) > 1) begin
                $display("FAIL wrap_onehot got=%b want=onehot_or_zero",
                    req_ready);
            end else passed++;
            if (res_valid === 1'b1) begin
                seen3 = 1;
                total++;
                if ({res_id, res_hundreds, res_tens, res_ones} !==
                    {2'd3, dec(77)}) begin
                    $display("FAIL wrap_res3 got=%h want=%h",
                        {res_id, res_hundreds, res_tens, res_ones},
                        {2'd3, dec(77)});
                end else passed++;
            end
            if (req_ready !== 4'b0000) break;
            tick();
        end
        total++;
        if (req_ready !== 4'b0100 || !seen3) begin
            $display("FAIL wrap_second got=%b seen3=%0d want=0100 seen3=1",
                req_ready, seen3);
        end else passed++;
        tick();
        req_valid = '0;
        wait_res(n);
        total++;
        if ({res_valid, res_id, res_hundreds, res_tens, res_ones} !==
            {1'b1, 2'd2, dec(42)}) begin
            $display("FAIL wrap_res2 got=%h want=%h",
                {res_valid, res_id, res_hundreds, res_tens, res_ones},
                {1'b1, 2'd2, dec(42)});
        end else passed++;
        tick();
    endtask

    task automatic test_reset_mid();
        int n;
        req_valid = 4'b0001;
        req_data = {24'h0, 8'd200};
        #1;
        wait_ready(n);
        total++;
        if (req_ready !== 4'b0001) begin
            $display("FAIL mid_grant got=%b want=0001", req_ready);
        end else passed++;
        tick();
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        total++;
        if ({req_ready, busy, res_valid, res_id,
             res_hundreds, res_tens, res_ones} !== 20'h0) begin
            $display("FAIL mid_abort got=%h want=00000",
                {req_ready, busy, res_valid, res_id,
                 res_hundreds, res_tens, res_ones});
        end else passed++;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        wait_ready(n);
        total++;
        if (req_ready !== 4'b0001 || res_valid !== 1'b0) begin
            $display("FAIL mid_regrant got=%b rv=%b want=0001 rv=0",
                req_ready, res_valid);
        end else passed++;
        tick();
        req_valid = '0;
        wait_res(n);
        total++;
        if (n != 8 || {res_id, res_hundreds, res_tens, res_ones} !==
            {2'd0, dec(200)}) begin
            $display("FAIL mid_result got=%h lat=%0d want=%h lat=8",
                {res_id, res_hundreds, res_tens, res_ones}, n,
                {2'd0, dec(200)});
        end else passed++;
        tick();
    endtask

    task automatic test_random();
        bit [3:0]  vld = '0;
        logic [7:0] dat[4];
        int skips[4] = '{0, 0, 0, 0};
        exp_t exp_q[$];
        exp_t e;
        int ptr = 0;
        int since = 99;
        int issued = 0;
        int w;
        int j;
        int c;
        logic [3:0] want;
        apply_reset();
        for (int i = 0; i < 4; i++) dat[i] = '0;
        for (c = 0; c < 20000; c++) begin
            if (issued >= 1000 && exp_q.size() == 0 && vld == 0) break;
            for (int i = 0; i < 4; i++) begin
                if (!vld[i] && issued < 1000 && $urandom_range(0, 3) == 0) begin
                    vld[i] = 1'b1;
                    dat[i] = 8'($urandom);
                    skips[i] = 0;
                end
            end
            req_valid = vld;
            req_data = {dat[3], dat[2], dat[1], dat[0]};
            #1;
            w = -1;
            if (since >= 9) begin
                for (int k = 0; k < 4; k++) begin
                    j = (ptr + k) % 4;
                    if (w < 0 && vld[j]) w = j;
                end
            end
            want = (w >= 0) ? 4'(1 << w) : 4'b0;
            total++;
            if (req_ready !== want) begin
                $display("FAIL rand_ready c=%0d got=%b want=%b",
                    c, req_ready, want);
            end else passed++;
            total++;
            if (res_valid !== (since == 8)) begin
                $display("FAIL rand_valid c=%0d got=%b want=%b",
                    c, res_valid, since == 8);
            end else passed++;
            if (since == 8) begin
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rand_result c=%0d got=extra want=none", c);
                end else begin
                    e = exp_q.pop_front();
                    if ({res_id, res_hundreds, res_tens, res_ones} !==
                        {2'(e.id), dec(e.val)}) begin
                        $display("FAIL rand_result c=%0d got=%h want=%h", c,
                            {res_id, res_hundreds, res_tens, res_ones},
                            {2'(e.id), dec(e.val)});
                    end else passed++;
                end
            end
            if (w >= 0) begin
                total++;
                if (skips[w] > 3) begin
                    $display("FAIL rand_starve id=%0d got=%0d want<=3",
                        w, skips[w]);
                end else passed++;
                for (int i = 0; i < 4; i++) begin
                    if (i != w && vld[i]) skips[i]++;
                end
                exp_q.push_back('{id: w, val: int'(dat[w])});
                ptr = (w + 1) % 4;
                issued++;
            end
            tick();
            since++;
            if (w >= 0) begin
                since = 0;
                vld[w] = 1'b0;
            end
        end
        total++;
        if (c >= 20000 || exp_q.size() != 0) begin
            $display("FAIL rand_timeout got=%0d pending want=0", exp_q.size());
        end else passed++;
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single_zero();
        test_back_to_back();
        test_all_four();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
